// File: rtl/wbs_pwm_pkg.sv
// Shared constants for the Wishbone PWM bank: register map, CTRL fields, bus request payload.
package wbs_pwm_pkg;

  localparam int unsigned ADR_W = 5;
  localparam int unsigned DAT_W = 16;

  localparam logic [ADR_W-1:0] ADR_CTRL   = 5'd0;
  localparam logic [ADR_W-1:0] ADR_PERIOD = 5'd1;
  localparam logic [ADR_W-1:0] ADR_DUTY0  = 5'd2;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_DIR_BIT   = 1;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

  function automatic logic [ADR_W-1:0] duty_adr(input int unsigned ch);
    return ADR_W'(32'(ADR_DUTY0) + ch);
  endfunction

endpackage

// File: rtl/wbs_pwm_bank_channel.sv
// One PWM channel: pending/active duty pair, boundary load, compare and registered output.
module wbs_pwm_bank_channel #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] pend_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (wr_i) pend_d = wdata_i;
    // Load sees the pre-write pending value, so a colliding write waits a full period.
    if (load_i) act_d = pend_q;
    pwm_d = en_i & (act_q > cnt_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      act_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pend_o = pend_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/wbs_pwm_bank.sv
// Multi-channel PWM bank with a Wishbone B4 pipelined slave port.
// Define WBS_PWM_CENTER_ALIGNED_EN for a triangle (centre-aligned) counter.
module wbs_pwm_bank
  import wbs_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic              wbs_clk_i,
  input  logic              wbs_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [ADR_W-1:0]  wbs_adr_i,
  input  logic [DAT_W-1:0]  wbs_dat_i,
  output logic [DAT_W-1:0]  wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_stall_o,
  output logic [NUM_CH-1:0] pwm_o
);

  wb_req_t          req;
  logic             req_c;
  logic             wr_c;

  logic             en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0] period_pend_q, period_pend_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [DAT_W-1:0] rdata_c;
  logic             tick_c;
  logic             wrap_c;
  logic             load_c;
  logic [CNT_W-1:0] duty_pend [NUM_CH];
`ifdef WBS_PWM_CENTER_ALIGNED_EN
  logic             dir_q, dir_d;
`endif

  assign req   = '{we: wbs_we_i, adr: wbs_adr_i, dat: wbs_dat_i};
  assign req_c = wbs_stb_i & wbs_cyc_i;
  assign wr_c  = req_c & req.we;

  // Control and period register writes; shadow copy on boundary or while disabled.
  always_comb begin
    en_d          = en_q;
    presc_d       = presc_q;
    period_pend_d = period_pend_q;
    if (wr_c && req.adr == ADR_CTRL) begin
      en_d    = req.dat[CTRL_EN_BIT];
      presc_d = PRESC_W'(req.dat >> CTRL_PRESC_LSB);
    end
    if (wr_c && req.adr == ADR_PERIOD) period_pend_d = CNT_W'(req.dat);
    period_act_d = load_c ? period_pend_q : period_act_q;
  end

  // Prescaler: one tick every presc_q+1 clocks while enabled.
  always_comb begin
    tick_c      = en_q & (presc_cnt_q >= presc_q);
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    if (!en_q || tick_c) presc_cnt_d = '0;
  end

  // Period counter; wrap_c marks the boundary tick where the counter returns to 0.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_c = 1'b0;
`ifdef WBS_PWM_CENTER_ALIGNED_EN
    dir_d  = dir_q;
    if (!en_q) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick_c) begin
      if (!dir_q) begin
        if (cnt_q >= period_act_q) begin
          if (period_act_q <= CNT_W'(1)) begin
            cnt_d  = '0;
            wrap_c = 1'b1;
          end else begin
            cnt_d = period_act_q - CNT_W'(1);
            dir_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (cnt_q <= CNT_W'(1)) begin
        cnt_d  = '0;
        dir_d  = 1'b0;
        wrap_c = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
`else
    if (!en_q) begin
      cnt_d = '0;
    end else if (tick_c) begin
      if (cnt_q >= period_act_q) begin
        cnt_d  = '0;
        wrap_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  assign load_c = wrap_c | ~en_q;

  // Readback of pending values, zero-extended.
  always_comb begin
    rdata_c = '0;
    if (req.adr == ADR_CTRL) begin
      rdata_c = (DAT_W'(en_q) << CTRL_EN_BIT) | (DAT_W'(presc_q) << CTRL_PRESC_LSB);
`ifdef WBS_PWM_CENTER_ALIGNED_EN
      rdata_c = rdata_c | (DAT_W'(dir_q) << CTRL_DIR_BIT);
`endif
    end else if (req.adr == ADR_PERIOD) begin
      rdata_c = DAT_W'(period_pend_q);
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req.adr == duty_adr(i)) rdata_c = DAT_W'(duty_pend[i]);
    end
    ack_d = req_c;
    dat_d = (req_c && !req.we) ? rdata_c : '0;
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
    if (!wbs_rst_ni) begin
      en_q          <= 1'b0;
      presc_q       <= '0;
      presc_cnt_q   <= '0;
      period_pend_q <= '0;
      period_act_q  <= '0;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      dat_q         <= '0;
`ifdef WBS_PWM_CENTER_ALIGNED_EN
      dir_q         <= 1'b0;
`endif
    end else begin
      en_q          <= en_d;
      presc_q       <= presc_d;
      presc_cnt_q   <= presc_cnt_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
`ifdef WBS_PWM_CENTER_ALIGNED_EN
      dir_q         <= dir_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wbs_pwm_bank_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i   (wbs_clk_i),
      .rst_ni  (wbs_rst_ni),
      .wr_i    (wr_c && (req.adr == duty_adr(g))),
      .wdata_i (CNT_W'(req.dat)),
      .load_i  (load_c),
      .en_i    (en_q),
      .cnt_i   (cnt_q),
      .pend_o  (duty_pend[g]),
      .pwm_o   (pwm_o[g])
    );
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign wbs_stall_o = 1'b0;

endmodule

// File: tb/tb_wbs_pwm_bank.sv
// Directed self-checking bench for wbs_pwm_bank (edge-aligned default build).
module tb_wbs_pwm_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [4:0]  adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        ack, stall;
  logic [3:0]  pwm;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  adr;
    logic        we;
    logic [15:0] wdat;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    bit lvl;
    int len;
  } run_t;

  run_t run_q[$];
  bit   mon_prev = 1'b0;
  int   mon_run  = 0;

  localparam int NV = 19;
  vec_t vt [NV];

  wbs_pwm_bank #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) dut (
    .wbs_clk_i   (clk),
    .wbs_rst_ni  (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_w),
    .wbs_dat_o   (dat_r),
    .wbs_ack_o   (ack),
    .wbs_stall_o (stall),
    .pwm_o       (pwm)
  );

  always #5 clk = ~clk;

  // Run-length recorder for pwm[0], sampled just after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_run  = 0;
    end else if (pwm[0] === mon_prev) begin
      mon_run++;
    end else begin
      if (mon_run > 0) run_q.push_back('{lvl: mon_prev, len: mon_run});
      mon_prev = pwm[0];
      mon_run  = 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives one strobe, checks single-cycle ack, returns at a negedge.
  task automatic wb_xfer(input logic [4:0] a, input logic w, input logic [15:0] d,
                         output logic [15:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d;
    @(negedge clk);
    check($sformatf("ack_hi_adr%0d", a), 32'(ack), 32'd1);
    rd = dat_r;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check($sformatf("ack_lo_adr%0d", a), 32'(ack), 32'd0);
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [15:0] d);
    logic [15:0] unused_rd;
    wb_xfer(a, 1'b1, d, unused_rd);
  endtask

  // Waits (bounded) for a 0->1 edge on pwm[0], then clears the run history.
  task automatic sync_rise(input string name);
    bit seen0 = 1'b0;
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pwm[0] === 1'b0) seen0 = 1'b1;
      else if (seen0) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
    run_q.delete();
  endtask

  task automatic check_run(input int idx, input bit lvl, input int len, input string name);
    if (idx < run_q.size())
      check(name, 32'(run_q[idx].lvl ? 1000 + run_q[idx].len : run_q[idx].len),
            32'(lvl ? 1000 + len : len));
    else
      check({name, "_count"}, 32'(run_q.size()), 32'(idx + 1));
  endtask

  task automatic count_high(input int ch, input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm[ch] === 1'b1) highs++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int          h;

    vt[0]  = '{5'd0,  1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{5'd1,  1'b0, 16'h0000, 16'h0000};
    vt[2]  = '{5'd2,  1'b0, 16'h0000, 16'h0000};
    vt[3]  = '{5'd3,  1'b0, 16'h0000, 16'h0000};
    vt[4]  = '{5'd4,  1'b0, 16'h0000, 16'h0000};
    vt[5]  = '{5'd5,  1'b0, 16'h0000, 16'h0000};
    vt[6]  = '{5'd6,  1'b0, 16'h0000, 16'h0000};
    vt[7]  = '{5'd31, 1'b0, 16'h0000, 16'h0000};
    vt[8]  = '{5'd0,  1'b1, 16'hFF02, 16'h0000};
    vt[9]  = '{5'd0,  1'b0, 16'h0000, 16'hFF00};
    vt[10] = '{5'd1,  1'b1, 16'hABCD, 16'h0000};
    vt[11] = '{5'd1,  1'b0, 16'h0000, 16'h00CD};
    vt[12] = '{5'd5,  1'b1, 16'h01FF, 16'h0000};
    vt[13] = '{5'd5,  1'b0, 16'h0000, 16'h00FF};
    vt[14] = '{5'd6,  1'b1, 16'h0055, 16'h0000};
    vt[15] = '{5'd6,  1'b0, 16'h0000, 16'h0000};
    vt[16] = '{5'd31, 1'b1, 16'hFFFF, 16'h0000};
    vt[17] = '{5'd31, 1'b0, 16'h0000, 16'h0000};
    vt[18] = '{5'd2,  1'b0, 16'h0000, 16'h0000};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    repeat (2) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", 32'(dat_r), 32'd0);
    check("stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      wb_xfer(vt[i].adr, vt[i].we, vt[i].wdat, rd);
      if (!vt[i].we) check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].exp));
    end
    check("pwm_idle", 32'(pwm), 32'd0);

    // PERIOD=9, DUTY0=3, DUTY1=10, DUTY2=0, PRESC=0
    wb_write(5'd0, 16'h0000);
    wb_write(5'd1, 16'd9);
    wb_write(5'd2, 16'd3);
    wb_write(5'd3, 16'd10);
    wb_write(5'd4, 16'd0);
    wb_write(5'd0, 16'h0001);
    sync_rise("sync_p9");
    repeat (25) @(negedge clk);
    check_run(0, 1'b1, 3, "p9_hi0");
    check_run(1, 1'b0, 7, "p9_lo0");
    check_run(2, 1'b1, 3, "p9_hi1");
    count_high(1, 20, h);
    check("ch1_const_hi", 32'(h), 32'd20);
    count_high(2, 20, h);
    check("ch2_const_lo", 32'(h), 32'd0);

    // Duty change mid-pulse applies only from the next period
    sync_rise("sync_mid");
    wb_write(5'd2, 16'd7);
    repeat (40) @(negedge clk);
    check_run(0, 1'b1, 3, "mid_hi_old");
    check_run(1, 1'b0, 7, "mid_lo_old");
    check_run(2, 1'b1, 7, "mid_hi_new");
    check_run(3, 1'b0, 3, "mid_lo_new");

    // PRESC=3, PERIOD=4, DUTY0=2
    wb_write(5'd0, 16'h0300);
    wb_write(5'd1, 16'd4);
    wb_write(5'd2, 16'd2);
    wb_write(5'd0, 16'h0301);
    sync_rise("sync_presc");
    repeat (45) @(negedge clk);
    check_run(0, 1'b1, 8,  "presc_hi0");
    check_run(1, 1'b0, 12, "presc_lo0");
    check_run(2, 1'b1, 8,  "presc_hi1");

    // Clearing EN in the middle of a high pulse
    sync_rise("sync_dis");
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 5'd0; dat_w = 16'h0300;
    @(negedge clk);
    check("dis_ack", 32'(ack), 32'd1);
    check("dis_pwm_still_hi", 32'(pwm[0]), 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check("dis_pwm_lo", 32'(pwm), 32'd0);
    count_high(0, 20, h);
    check("dis_stays_lo", 32'(h), 32'd0);
    wb_xfer(5'd0, 1'b0, 16'h0000, rd);
    check("dis_ctrl_rd", 32'(rd), 32'h0300);

    // Back-to-back reads
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 5'd1;
    @(negedge clk);
    check("b2b_ack0", 32'(ack), 32'd1);
    check("b2b_dat0", 32'(dat_r), 32'd4);
    adr = 5'd2;
    @(negedge clk);
    check("b2b_ack1", 32'(ack), 32'd1);
    check("b2b_dat1", 32'(dat_r), 32'd2);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("b2b_ack_end", 32'(ack), 32'd0);

    // Reset in the middle of a running period
    wb_write(5'd0, 16'h0001);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_pwm", 32'(pwm), 32'd0);
    check("mrst_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_xfer(5'd0, 1'b0, 16'h0000, rd);
    check("mrst_ctrl", 32'(rd), 32'd0);
    wb_xfer(5'd1, 1'b0, 16'h0000, rd);
    check("mrst_period", 32'(rd), 32'd0);
    wb_xfer(5'd3, 1'b0, 16'h0000, rd);
    check("mrst_duty1", 32'(rd), 32'd0);
    count_high(1, 10, h);
    check("mrst_pwm_lo", 32'(h), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
